imem_loader: RTL

Boot-time program loader on the instruction-memory write side of the pipelined core. It accepts a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written into instruction memory through a write port, and the core is held in reset until a frame completes with a good checksum. The core's fetch stage then reads what this block wrote.

---
 rtl/imem_loader_if.sv | 39 +++
 rtl/imem_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Groups the byte-stream handshake and the instruction-memory write port of
// the boot loader.
//   in_data    [7:0]  stream byte                  (source -> loader)
//   in_valid          in_data valid                (source -> loader)
//   in_ready          loader accepts a byte        (loader -> source)
//   imem_we           one-cycle write strobe       (loader -> memory)
//   imem_waddr [31:0] word-aligned byte address    (loader -> memory)
//   imem_wdata [31:0] word to write                (loader -> memory)
// The master side sources bytes and observes the writes. The slave side is
// the loader.
// -----------------------------------------------------------------------------
interface imem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  imem_we,
    input  imem_waddr,
    input  imem_wdata
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output imem_we,
    output imem_waddr,
    output imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Boot-time program loader. It accepts a framed byte stream:
//   LEN_LO, LEN_HI (word count N), 4*N payload bytes (little endian), XOR csum
// Each completed word goes to instruction memory, and the core is held in reset
// until a frame completes with a matching checksum.
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   start         single-cycle pulse, honoured in IDLE/DONE/ERROR only
//   bus           stream handshake + instruction-memory write port (slave)
//   cpu_hold      core held in reset while high
//   load_done     frame loaded and checksum verified
//   load_err      00 none, 01 length > DEPTH, 10 checksum mismatch
//   words_loaded  number of write strobes since the last start
// Every output is driven straight from a flop.
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int unsigned DEPTH = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          cpu_hold,
  output logic          load_done,
  output logic [1:0]    load_err,
  output logic [15:0]   words_loaded
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  localparam logic [15:0] DEPTH_W   = 16'(DEPTH);
  localparam logic [1:0]  ERR_NONE  = 2'b00;
  localparam logic [1:0]  ERR_LEN   = 2'b01;
  localparam logic [1:0]  ERR_CSUM  = 2'b10;

  // The stream is accepted only while a frame is being parsed.
  function automatic logic takes_bytes(input state_t s);
    logic r;
    case (s)
      ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM: r = 1'b1;
      default:                                r = 1'b0;
    endcase
    return r;
  endfunction

  // Byte address of a word, which uses the same addressing as the fetch pc.
  function automatic logic [31:0] word_addr(input logic [15:0] idx);
    return {14'd0, idx, 2'b00};
  endfunction

  // State and datapath registers
  state_t       state_r,        state_d;
  logic [7:0]   len_lo_r,       len_lo_d;
  logic [15:0]  len_r,          len_d;
  logic [15:0]  word_idx_r,     word_idx_d;
  logic [1:0]   byte_idx_r,     byte_idx_d;
  logic [7:0]   xor_r,          xor_d;
  logic [23:0]  word_buf_r,     word_buf_d;

  // Output registers
  logic         in_ready_r,     in_ready_d;
  logic         we_r,           we_d;
  logic [31:0]  waddr_r,        waddr_d;
  logic [31:0]  wdata_r,        wdata_d;
  logic         cpu_hold_r,     cpu_hold_d;
  logic         load_done_r,    load_done_d;
  logic [1:0]   load_err_r,     load_err_d;
  logic [15:0]  words_loaded_r, words_loaded_d;

  logic         xfer_s;
  logic         start_ok_s;
  logic [15:0]  len_full_s;

  // in_ready_r mirrors the state, so a transfer never depends on in_valid
  // combinationally through the loader.
  assign xfer_s     = bus.in_valid & in_ready_r;
  assign start_ok_s = start & ((state_r == ST_IDLE) | (state_r == ST_DONE) |
                               (state_r == ST_ERROR));
  assign len_full_s = {bus.in_data, len_lo_r};

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_d;
    end
  end

  // Next-state and next-register logic
  always_comb begin
    state_d        = state_r;
    len_lo_d       = len_lo_r;
    len_d          = len_r;
    word_idx_d     = word_idx_r;
    byte_idx_d     = byte_idx_r;
    xor_d          = xor_r;
    word_buf_d     = word_buf_r;
    we_d           = 1'b0;
    waddr_d        = waddr_r;
    wdata_d        = wdata_r;
    cpu_hold_d     = cpu_hold_r;
    load_done_d    = load_done_r;
    load_err_d     = load_err_r;
    words_loaded_d = words_loaded_r;

    if (start_ok_s) begin
      // A start that is accepted takes priority over a byte. in_ready is low
      // in these states, so the byte is not consumed.
      state_d        = ST_LEN_LO;
      word_idx_d     = 16'd0;
      byte_idx_d     = 2'd0;
      xor_d          = 8'd0;
      word_buf_d     = 24'd0;
      cpu_hold_d     = 1'b1;
      load_done_d    = 1'b0;
      load_err_d     = ERR_NONE;
      words_loaded_d = 16'd0;
    end else begin
      case (state_r)
        ST_LEN_LO: begin
          if (xfer_s) begin
            len_lo_d = bus.in_data;
            state_d  = ST_LEN_HI;
          end else begin
            state_d  = ST_LEN_LO;
          end
        end

        ST_LEN_HI: begin
          if (xfer_s) begin
            len_d = len_full_s;
            if (len_full_s > DEPTH_W) begin
              state_d    = ST_ERROR;
              load_err_d = ERR_LEN;
              cpu_hold_d = 1'b1;
            end else if (len_full_s == 16'd0) begin
              state_d = ST_CSUM;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            state_d = ST_LEN_HI;
          end
        end

        ST_DATA: begin
          if (xfer_s) begin
            xor_d      = xor_r ^ bus.in_data;
            byte_idx_d = byte_idx_r + 2'd1;
            case (byte_idx_r)
              2'd0: word_buf_d[7:0]   = bus.in_data;
              2'd1: word_buf_d[15:8]  = bus.in_data;
              2'd2: word_buf_d[23:16] = bus.in_data;
              2'd3: begin
                // The 4th byte completes the word. The strobe appears on the
                // next cycle, together with the address and data.
                we_d           = 1'b1;
                wdata_d        = {bus.in_data, word_buf_r};
                waddr_d        = word_addr(word_idx_r);
                word_idx_d     = word_idx_r + 16'd1;
                words_loaded_d = words_loaded_r + 16'd1;
                if (word_idx_r == (len_r - 16'd1)) begin
                  state_d = ST_CSUM;
                end else begin
                  state_d = ST_DATA;
                end
              end
              default: word_buf_d = word_buf_r;
            endcase
          end else begin
            state_d = ST_DATA;
          end
        end

        ST_CSUM: begin
          if (xfer_s) begin
            if (bus.in_data == xor_r) begin
              state_d     = ST_DONE;
              load_done_d = 1'b1;
              cpu_hold_d  = 1'b0;
            end else begin
              state_d     = ST_ERROR;
              load_err_d  = ERR_CSUM;
              cpu_hold_d  = 1'b1;
            end
          end else begin
            state_d = ST_CSUM;
          end
        end

        ST_IDLE, ST_DONE, ST_ERROR: begin
          state_d = state_r;
        end

        default: begin
          // Unreachable encodings recover to a safe, held state.
          state_d     = ST_IDLE;
          cpu_hold_d  = 1'b1;
          load_done_d = 1'b0;
        end
      endcase
    end

    in_ready_d = takes_bytes(state_d);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_lo_r       <= 8'd0;
      len_r          <= 16'd0;
      word_idx_r     <= 16'd0;
      byte_idx_r     <= 2'd0;
      xor_r          <= 8'd0;
      word_buf_r     <= 24'd0;
      in_ready_r     <= 1'b0;
      we_r           <= 1'b0;
      waddr_r        <= 32'd0;
      wdata_r        <= 32'd0;
      cpu_hold_r     <= 1'b1;
      load_done_r    <= 1'b0;
      load_err_r     <= ERR_NONE;
      words_loaded_r <= 16'd0;
    end else begin
      len_lo_r       <= len_lo_d;
      len_r          <= len_d;
      word_idx_r     <= word_idx_d;
      byte_idx_r     <= byte_idx_d;
      xor_r          <= xor_d;
      word_buf_r     <= word_buf_d;
      in_ready_r     <= in_ready_d;
      we_r           <= we_d;
      waddr_r        <= waddr_d;
      wdata_r        <= wdata_d;
      cpu_hold_r     <= cpu_hold_d;
      load_done_r    <= load_done_d;
      load_err_r     <= load_err_d;
      words_loaded_r <= words_loaded_d;
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.imem_we    = we_r;
  assign bus.imem_waddr = waddr_r;
  assign bus.imem_wdata = wdata_r;
  assign cpu_hold       = cpu_hold_r;
  assign load_done      = load_done_r;
  assign load_err       = load_err_r;
  assign words_loaded   = words_loaded_r;

endmodule
